// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, initial hash value, the FIPS 180-4
// bit functions, and the core's state/word types.
package sha256_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        OUT
    } state_t;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: working variables a..h (a in [255:224]) plus K_t, W_t
// produce the next a..h. Chained ROUNDS_PER_CYCLE deep by the core.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] state_in,
    input  logic [31:0]  k,
    input  logic [31:0]  w,
    output logic [255:0] state_out
);

    word_t a, b, c, d, e, f, g, h;
    word_t t1, t2;

    assign {a, b, c, d, e, f, g, h} = state_in;

    assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
    assign t2 = big_sigma0(a) + maj(a, b, c);

    assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_core_param.sv
// SHA-256 compression core, ROUNDS_PER_CYCLE rounds per clock, valid/ready on input and
// output. Each block chains from the standard IV or from a caller-supplied prev_digest.
module sha256_core_param
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block_in,
    input  logic [255:0] prev_digest,
    input  logic         first_block,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest
);

    localparam int ROUND_CYCLES = 64 / ROUNDS_PER_CYCLE;

    state_t       state, state_next;
    logic [5:0]   cnt;
    logic         last_round;
    logic [255:0] h_q;
    logic [255:0] work_q;
    logic [255:0] h_init;
    logic [255:0] digest_sum;
    word_t        w_q   [16];
    word_t        w_ext [16 + ROUNDS_PER_CYCLE];
    logic [255:0] chain [ROUNDS_PER_CYCLE + 1];

    assign last_round   = (cnt == 6'(ROUND_CYCLES - 1));
    assign in_ready     = (state == IDLE) && !reset;
    assign digest_valid = (state == OUT);
    assign h_init       = first_block ? IV : prev_digest;

    // Window extended by the R schedule words needed this clock; w_ext[j] feeds round j.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_ext[i] = w_q[i];
        end
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            w_ext[16 + j] = small_sigma1(w_ext[14 + j]) + w_ext[9 + j]
                          + small_sigma0(w_ext[1 + j]) + w_ext[j];
        end
    end

    assign chain[0] = work_q;

    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
        logic [5:0] t_idx;
        assign t_idx = cnt * 6'(ROUNDS_PER_CYCLE) + 6'(j);

        sha256_round u_round (
            .state_in  (chain[j]),
            .k         (K[t_idx]),
            .w         (w_ext[j]),
            .state_out (chain[j + 1])
        );
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            digest_sum[255 - 32*i -: 32] = h_q[255 - 32*i -: 32] + work_q[255 - 32*i -: 32];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers update from
            // the same pre-edge values, independent of statement order.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: the default assignment first means every path drives state_next, so no
        // latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (in_valid)     state_next = ROUND;
            ROUND:   if (last_round)   state_next = FINAL;
            FINAL:                     state_next = OUT;
            OUT:     if (digest_ready) state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            h_q    <= '0;
            work_q <= '0;
            digest <= '0;
            // NOTE: the window is only 16 words of flops, not a RAM, so clearing it on
            // reset is cheap and keeps an aborted block from leaking into the next one.
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt    <= '0;
                        h_q    <= h_init;
                        work_q <= h_init;
                        for (int i = 0; i < 16; i++) begin
                            w_q[i] <= block_in[511 - 32*i -: 32];
                        end
                    end
                end
                ROUND: begin
                    cnt    <= cnt + 6'd1;
                    work_q <= chain[ROUNDS_PER_CYCLE];
                    for (int i = 0; i < 16; i++) begin
                        w_q[i] <= w_ext[i + ROUNDS_PER_CYCLE];
                    end
                end
                FINAL: digest <= digest_sum;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_core_param.sv
// Directed bench: one core per ROUNDS_PER_CYCLE in {1,2,4,8}, each exercised in turn with
// FIPS 180-4 example vectors, backpressure, mid-block reset and back-to-back blocks.
module tb_sha256_core_param;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_TWO1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

    localparam logic [255:0] DIG_ABC   =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] DIG_TWO1  =
        256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
    localparam logic [255:0] DIG_TWO   =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] GARBAGE   =
        256'hdeadbeef_01234567_89abcdef_cafef00d_a5a5a5a5_5a5a5a5a_13579bdf_2468ace0;

    logic         clk;
    logic         reset;
    logic         in_valid     [4];
    logic         in_ready     [4];
    logic [511:0] block_in     [4];
    logic [255:0] prev_digest  [4];
    logic         first_block  [4];
    logic         digest_valid [4];
    logic         digest_ready [4];
    logic [255:0] digest       [4];

    int vectors = 0;
    int misses  = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sha256_core_param #(.ROUNDS_PER_CYCLE(1 << g)) dut (
            .clk          (clk),
            .reset        (reset),
            .in_valid     (in_valid[g]),
            .in_ready     (in_ready[g]),
            .block_in     (block_in[g]),
            .prev_digest  (prev_digest[g]),
            .first_block  (first_block[g]),
            .digest_valid (digest_valid[g]),
            .digest_ready (digest_ready[g]),
            .digest       (digest[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Presents a block at a negedge and returns just after the accept edge, with the
    // inputs scrambled so only values sampled at that edge can influence the result.
    task automatic start_block(input int idx, input logic [511:0] blk, input logic [255:0] prev,
                               input logic first, output bit ok);
        int guard = 0;
        @(negedge clk);
        block_in[idx]    = blk;
        prev_digest[idx] = prev;
        first_block[idx] = first;
        in_valid[idx]    = 1'b1;
        while (in_ready[idx] !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (in_ready[idx] !== 1'b1) begin
            $display("FAIL accept_timeout R=%0d: in_ready=%b required 1", 1 << idx, in_ready[idx]);
            misses++;
            in_valid[idx] = 1'b0;
            ok = 1'b0;
            return;
        end
        ok = 1'b1;
        @(posedge clk);
        #1;
        in_valid[idx]    = 1'b0;
        block_in[idx]    = ~blk;
        prev_digest[idx] = ~prev;
        first_block[idx] = ~first;
    endtask

    // Counts clocks from the edge that opens the accept cycle (accept edge = 1) until
    // digest_valid is seen; required count is ROUND_CYCLES+2. Returns at that negedge.
    task automatic wait_digest(input int idx, input string name, output int lat);
        int rc = 64 >> idx;
        lat = 1;
        forever begin
            @(negedge clk);
            if (digest_valid[idx] === 1'b1 || lat >= 300) break;
            @(posedge clk);
            lat++;
        end
        vectors++;
        if (digest_valid[idx] !== 1'b1) begin
            $display("FAIL %s_timeout R=%0d: digest_valid never rose", name, 1 << idx);
            misses++;
            lat = -1;
        end else if (lat != rc + 2) begin
            $display("FAIL %s_latency R=%0d: got %0d clocks, required %0d", name, 1 << idx, lat, rc + 2);
            misses++;
        end
    endtask

    task automatic test_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (in_ready[i] !== 1'b0 || digest_valid[i] !== 1'b0 || digest[i] !== 256'h0) begin
                $display("FAIL reset_state R=%0d: in_ready=%b digest_valid=%b digest=%h, required 0/0/0",
                         1 << i, in_ready[i], digest_valid[i], digest[i]);
                misses++;
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (in_ready[i] !== 1'b1) begin
                $display("FAIL reset_release R=%0d: in_ready=%b required 1", 1 << i, in_ready[i]);
                misses++;
            end
        end
    endtask

    task automatic run_single(input int idx, input string name, input logic [511:0] blk,
                              input logic [255:0] prev, input logic first,
                              input logic [255:0] expected);
        bit ok;
        int lat;
        digest_ready[idx] = 1'b1;
        start_block(idx, blk, prev, first, ok);
        if (!ok) return;
        wait_digest(idx, name, lat);
        if (lat < 0) return;
        vectors++;
        if (digest[idx] !== expected) begin
            $display("FAIL %s_digest R=%0d: got %h required %h", name, 1 << idx, digest[idx], expected);
            misses++;
        end
        @(negedge clk);
        vectors++;
        if (digest_valid[idx] !== 1'b0 || in_ready[idx] !== 1'b1) begin
            $display("FAIL %s_release R=%0d: digest_valid=%b in_ready=%b, required 0/1",
                     name, 1 << idx, digest_valid[idx], in_ready[idx]);
            misses++;
        end
    endtask

    task automatic test_abc(input int idx);
        run_single(idx, "abc", BLK_ABC, GARBAGE, 1'b1, DIG_ABC);
    endtask

    task automatic test_empty(input int idx);
        run_single(idx, "empty", BLK_EMPTY, GARBAGE, 1'b1, DIG_EMPTY);
    endtask

    task automatic test_two_block(input int idx);
        run_single(idx, "two_blk1", BLK_TWO1, GARBAGE, 1'b1, DIG_TWO1);
        run_single(idx, "two_blk2", BLK_TWO2, DIG_TWO1, 1'b0, DIG_TWO);
    endtask

    task automatic test_backpressure(input int idx);
        bit ok;
        int lat;
        int rc = 64 >> idx;
        digest_ready[idx] = 1'b0;
        start_block(idx, BLK_ABC, GARBAGE, 1'b1, ok);
        if (!ok) return;
        wait_digest(idx, "bp", lat);
        if (lat < 0) return;
        for (int k = 0; k < 20; k++) begin
            in_valid[idx]    = (k % 4 == 0);
            block_in[idx]    = BLK_EMPTY;
            first_block[idx] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (digest[idx] !== DIG_ABC || digest_valid[idx] !== 1'b1 || in_ready[idx] !== 1'b0) begin
                $display("FAIL bp_hold R=%0d cycle %0d: digest=%h valid=%b in_ready=%b, required %h/1/0",
                         1 << idx, k, digest[idx], digest_valid[idx], in_ready[idx], DIG_ABC);
                misses++;
            end
        end
        in_valid[idx]     = 1'b0;
        digest_ready[idx] = 1'b1;
        @(negedge clk);
        vectors++;
        if (digest_valid[idx] !== 1'b0 || in_ready[idx] !== 1'b1) begin
            $display("FAIL bp_release R=%0d: digest_valid=%b in_ready=%b, required 0/1",
                     1 << idx, digest_valid[idx], in_ready[idx]);
            misses++;
        end
        repeat (rc + 5) @(negedge clk);
        vectors++;
        if (digest_valid[idx] !== 1'b0 || in_ready[idx] !== 1'b1) begin
            $display("FAIL bp_no_ghost R=%0d: digest_valid=%b in_ready=%b, required 0/1",
                     1 << idx, digest_valid[idx], in_ready[idx]);
            misses++;
        end
    endtask

    task automatic test_reset_mid(input int idx);
        bit ok;
        int rc = 64 >> idx;
        digest_ready[idx] = 1'b1;
        start_block(idx, BLK_EMPTY, GARBAGE, 1'b1, ok);
        if (!ok) return;
        repeat (rc / 2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (digest_valid[idx] !== 1'b0 || in_ready[idx] !== 1'b0 || digest[idx] !== 256'h0) begin
            $display("FAIL midreset_state R=%0d: valid=%b in_ready=%b digest=%h, required 0/0/0",
                     1 << idx, digest_valid[idx], in_ready[idx], digest[idx]);
            misses++;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++;
        if (in_ready[idx] !== 1'b1) begin
            $display("FAIL midreset_release R=%0d: in_ready=%b required 1", 1 << idx, in_ready[idx]);
            misses++;
        end
        repeat (rc + 5) @(negedge clk);
        vectors++;
        if (digest_valid[idx] !== 1'b0) begin
            $display("FAIL midreset_abort R=%0d: digest_valid=%b required 0", 1 << idx, digest_valid[idx]);
            misses++;
        end
        test_abc(idx);
    endtask

    task automatic test_back_to_back(input int idx);
        int rc = 64 >> idx;
        int cyc = 0;
        int seen = 0;
        int times [3];
        digest_ready[idx] = 1'b1;
        @(negedge clk);
        block_in[idx]    = BLK_ABC;
        prev_digest[idx] = GARBAGE;
        first_block[idx] = 1'b1;
        in_valid[idx]    = 1'b1;
        while (seen < 3 && cyc < 4 * (rc + 3) + 20) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (digest_valid[idx] === 1'b1) begin
                vectors++;
                if (digest[idx] !== DIG_ABC) begin
                    $display("FAIL b2b_digest R=%0d #%0d: got %h required %h", 1 << idx, seen, digest[idx], DIG_ABC);
                    misses++;
                end
                times[seen] = cyc;
                seen++;
                if (seen == 3) in_valid[idx] = 1'b0;
            end
        end
        in_valid[idx] = 1'b0;
        vectors++;
        if (seen != 3) begin
            $display("FAIL b2b_count R=%0d: got %0d digests required 3", 1 << idx, seen);
            misses++;
            return;
        end
        vectors++;
        if (times[0] != rc + 2) begin
            $display("FAIL b2b_first R=%0d: got %0d clocks required %0d", 1 << idx, times[0], rc + 2);
            misses++;
        end
        for (int k = 1; k < 3; k++) begin
            vectors++;
            if (times[k] - times[k - 1] != rc + 3) begin
                $display("FAIL b2b_spacing R=%0d gap %0d: got %0d clocks required %0d",
                         1 << idx, k, times[k] - times[k - 1], rc + 3);
                misses++;
            end
        end
        @(negedge clk);
        vectors++;
        if (in_ready[idx] !== 1'b1 || digest_valid[idx] !== 1'b0) begin
            $display("FAIL b2b_idle R=%0d: in_ready=%b digest_valid=%b, required 1/0",
                     1 << idx, in_ready[idx], digest_valid[idx]);
            misses++;
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid[i]     = 1'b0;
            block_in[i]     = '0;
            prev_digest[i]  = '0;
            first_block[i]  = 1'b0;
            digest_ready[i] = 1'b1;
        end
        test_reset();
        for (int i = 0; i < 4; i++) begin
            test_abc(i);
            test_empty(i);
            test_two_block(i);
            test_backpressure(i);
            test_reset_mid(i);
            test_back_to_back(i);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
